// File: rtl/mem_stage_ext_pkg.sv
// Shared definitions for the MEM stage: bus widths, load op encodings and sizing constants.
// XLEN is fixed at 32 in this generation; the other files rely on that.
package mem_stage_ext_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned DEST_W    = 5;
    localparam int unsigned MAX_OUTST = 2;

    localparam int unsigned ES_TO_MS_WD = 3 + 1 + 1 + DEST_W + 2 * XLEN;
    localparam int unsigned MS_TO_WS_WD = 1 + DEST_W + 2 * XLEN;
    localparam int unsigned MS_FWD_WD   = 1 + 1 + DEST_W + XLEN;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_BU = 3'd2,
        LD_H  = 3'd3,
        LD_HU = 3'd4
    } ld_op_e;

endpackage

// File: rtl/mem_stage_ext_load_align.sv
// Combinational load data alignment and sign/zero extension.
// Unknown ld_op encodings fall back to a full word.
module load_align
    import mem_stage_ext_pkg::*;
(
    input  logic [2:0]  ld_op,
    input  logic [1:0]  offset,
    input  logic [31:0] raw_data,
    output logic [31:0] ext_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw_data[{offset, 3'b000} +: 8];
        // Halves use only offset[1]; a misaligned offset[0] is EX's problem.
        half_sel = offset[1] ? raw_data[31:16] : raw_data[15:0];
        case (ld_op)
            LD_B:    ext_data = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   ext_data = {24'b0, byte_sel};
            LD_H:    ext_data = {{16{half_sel[15]}}, half_sel};
            LD_HU:   ext_data = {16'b0, half_sel};
            default: ext_data = raw_data;
        endcase
    end

endmodule

// File: rtl/mem_stage_ext.sv
// MEM pipeline stage with variable-latency data memory, early-data buffering,
// a forwarding/hazard bus to ID and flush handling that discards orphaned responses.
module mem_stage_ext
    import mem_stage_ext_pkg::*;
#(
    parameter int unsigned XLEN      = mem_stage_ext_pkg::XLEN,
    parameter int unsigned DEST_W    = mem_stage_ext_pkg::DEST_W,
    parameter int unsigned MAX_OUTST = mem_stage_ext_pkg::MAX_OUTST
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            es_to_ms_valid,
    input  logic [3+1+1+DEST_W+2*XLEN-1:0]  es_to_ms_bus,
    input  logic                            ws_allow_in,
    input  logic                            data_sram_data_ok,
    input  logic [XLEN-1:0]                 data_sram_rdata,
    output logic                            ms_allow_in,
    output logic                            ms_to_ws_valid,
    output logic [1+DEST_W+2*XLEN-1:0]      ms_to_ws_bus,
    output logic [1+1+DEST_W+XLEN-1:0]      ms_fwd_bus
);

    localparam int unsigned EsWd = 3 + 1 + 1 + DEST_W + 2 * XLEN;
    localparam int unsigned CntW = $clog2(MAX_OUTST + 1);

    logic                ms_valid_q;
    logic [EsWd-1:0]     es_bus_q;
    logic                data_buf_valid_q;
    logic [XLEN-1:0]     data_buf_q;
    logic [CntW-1:0]     discard_cnt_q, discard_cnt_d;

    logic [2:0]          ld_op;
    logic                mem_req, rf_we;
    logic [DEST_W-1:0]   dest;
    logic [XLEN-1:0]     pc, alu_result;
    logic                es_mem_req;

    logic                cnt_zero, resp_hit, ms_ready_go, ms_leave, buf_load;
    logic                inc_ms, inc_es, dec_cnt;
    logic [XLEN-1:0]     raw_data, load_data, final_result;
    int unsigned         cnt_sum;

    assign alu_result = es_bus_q[XLEN-1:0];
    assign pc         = es_bus_q[2*XLEN-1:XLEN];
    assign dest       = es_bus_q[2*XLEN+DEST_W-1 -: DEST_W];
    assign rf_we      = es_bus_q[2*XLEN+DEST_W];
    assign mem_req    = es_bus_q[2*XLEN+DEST_W+1];
    assign ld_op      = es_bus_q[EsWd-1 -: 3];
    assign es_mem_req = es_to_ms_bus[2*XLEN+DEST_W+1];

    // A response only belongs to the held entry once all orphaned ones are drained.
    assign cnt_zero       = (discard_cnt_q == '0);
    assign resp_hit       = data_sram_data_ok && cnt_zero;
    assign ms_ready_go    = !mem_req || data_buf_valid_q || resp_hit;
    assign ms_allow_in    = !ms_valid_q || (ms_ready_go && ws_allow_in);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go && !flush;
    assign ms_leave       = ms_to_ws_valid && ws_allow_in;
    assign buf_load       = resp_hit && ms_valid_q && mem_req && !data_buf_valid_q && !ws_allow_in;

    assign raw_data = data_buf_valid_q ? data_buf_q : data_sram_rdata;

    load_align u_load_align (
        .ld_op    (ld_op),
        .offset   (alu_result[1:0]),
        .raw_data (raw_data),
        .ext_data (load_data)
    );

    assign final_result = mem_req ? load_data : alu_result;

    assign ms_to_ws_bus = {rf_we, dest, pc, final_result};
    assign ms_fwd_bus   = {ms_valid_q && rf_we, ms_valid_q && mem_req && !ms_ready_go,
                           dest, final_result};

    // Flushed loads still waiting on memory, and loads dropped on entry, leave orphans.
    assign inc_ms  = flush && ms_valid_q && !ms_ready_go;
    assign inc_es  = flush && ms_allow_in && es_to_ms_valid && es_mem_req;
    assign dec_cnt = data_sram_data_ok && !cnt_zero;

    always_comb begin
        cnt_sum = 32'(discard_cnt_q) + 32'(inc_ms) + 32'(inc_es) - 32'(dec_cnt);
        if (cnt_sum > MAX_OUTST) begin
            cnt_sum = MAX_OUTST;
        end
        discard_cnt_d = CntW'(cnt_sum);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ms_valid_q       <= 1'b0;
            es_bus_q         <= '0;
            data_buf_valid_q <= 1'b0;
            data_buf_q       <= '0;
            discard_cnt_q    <= '0;
        end else begin
            if (ms_allow_in || flush) begin
                ms_valid_q <= es_to_ms_valid && !flush;
            end
            if (ms_allow_in && es_to_ms_valid && !flush) begin
                es_bus_q <= es_to_ms_bus;
            end
            if (flush || ms_leave) begin
                data_buf_valid_q <= 1'b0;
            end else if (buf_load) begin
                data_buf_valid_q <= 1'b1;
                data_buf_q       <= data_sram_rdata;
            end
            discard_cnt_q <= discard_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_ext.sv
// Bench for mem_stage_ext: directed scenarios followed by randomized traffic checked
// against a transaction-level model that tracks outstanding responses as a tagged queue.
module tb_mem_stage_ext;
    import mem_stage_ext_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst, flush, es_to_ms_valid, ws_allow_in, data_sram_data_ok;
    logic [ES_TO_MS_WD-1:0] es_to_ms_bus;
    logic [31:0]            data_sram_rdata;
    logic                   ms_allow_in, ms_to_ws_valid;
    logic [MS_TO_WS_WD-1:0] ms_to_ws_bus;
    logic [MS_FWD_WD-1:0]   ms_fwd_bus;

    int checks = 0;
    int errors = 0;

    mem_stage_ext dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ws_allow_in       (ws_allow_in),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_allow_in       (ms_allow_in),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_fwd_bus        (ms_fwd_bus)
    );

    always #5 clk = ~clk;

    logic [31:0] res;
    logic        fwd_we, fwd_block;
    assign res       = ms_to_ws_bus[31:0];
    assign fwd_we    = ms_fwd_bus[MS_FWD_WD-1];
    assign fwd_block = ms_fwd_bus[MS_FWD_WD-2];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ES_TO_MS_WD-1:0] mk(input logic [2:0] op, input logic mreq,
                                                  input logic we, input logic [4:0] dst,
                                                  input logic [31:0] pcv, input logic [31:0] alu);
        return {op, mreq, we, dst, pcv, alu};
    endfunction

    // Reference extension written with shifts and signed casts.
    function automatic logic [31:0] ref_ext(input logic [2:0] op, input logic [1:0] a,
                                            input logic [31:0] w);
        logic [31:0] sb, sh;
        sb = (w >> (8 * int'(a))) & 32'hFF;
        sh = (w >> (16 * (int'(a) / 2))) & 32'hFFFF;
        case (op)
            3'd1:    return (sb >= 32'h80) ? (sb | 32'hFFFF_FF00) : sb;
            3'd2:    return sb;
            3'd3:    return (sh >= 32'h8000) ? (sh | 32'hFFFF_0000) : sh;
            3'd4:    return sh;
            default: return w;
        endcase
    endfunction

    // Model state: one held entry plus in-order outstanding responses (1 = live, 0 = orphan).
    bit          m_valid, m_mreq, m_we, m_has;
    logic [2:0]  m_op;
    logic [4:0]  m_dest;
    logic [31:0] m_pc, m_alu, m_data;
    bit          resp_q[$];

    initial begin
        bit          got, ready, allow, ovalid, mreq, we;
        logic [2:0]  op;
        logic [4:0]  dst;
        logic [31:0] pcv, alu, exp_res;

        rst = 1'b1; flush = 1'b0; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
        ws_allow_in = 1'b1; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", ms_to_ws_valid, 0);
        chk("rst_fwd_we", fwd_we, 0);
        chk("rst_fwd_block", fwd_block, 0);
        chk("rst_allow", ms_allow_in, 1);

        // ALU pass-through
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(3'd0, 1'b0, 1'b1, 5'd3, 32'h100, 32'h1234);
        @(negedge clk); es_to_ms_valid = 1'b0; #1;
        chk("alu_valid", ms_to_ws_valid, 1);
        chk("alu_res", res, 32'h0000_1234);
        chk("alu_block", fwd_block, 0);
        chk("alu_fwd_we", fwd_we, 1);

        // LB / LBU at offset 3 with two wait cycles
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            es_to_ms_valid = 1'b1;
            es_to_ms_bus   = mk((k == 0) ? 3'd1 : 3'd2, 1'b1, 1'b1, 5'd7, 32'h200, 32'h1003);
            @(negedge clk); es_to_ms_valid = 1'b0;
            for (int w = 0; w < 2; w++) begin
                #1;
                chk("lb_wait_block", fwd_block, 1);
                chk("lb_wait_allow", ms_allow_in, 0);
                chk("lb_wait_valid", ms_to_ws_valid, 0);
                @(negedge clk);
            end
            data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_FF7F; #1;
            chk("lb_valid", ms_to_ws_valid, 1);
            chk("lb_res", res, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
            chk("lb_block", fwd_block, 0);
            @(negedge clk); data_sram_data_ok = 1'b0;
        end

        // LHU at offset 2, early data buffered while WB stalls
        @(negedge clk);
        es_to_ms_valid = 1'b1; es_to_ms_bus = mk(3'd4, 1'b1, 1'b1, 5'd9, 32'h300, 32'h2002);
        @(negedge clk);
        es_to_ms_valid = 1'b0; ws_allow_in = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hABCD_0000; #1;
        chk("lhu_first_valid", ms_to_ws_valid, 1);
        chk("lhu_first_allow", ms_allow_in, 0);
        chk("lhu_first_res", res, 32'h0000_ABCD);
        for (int w = 0; w < 2; w++) begin
            @(negedge clk); data_sram_data_ok = 1'b0; data_sram_rdata = 32'h5A5A_1234 + w; #1;
            chk("lhu_buf_valid", ms_to_ws_valid, 1);
            chk("lhu_buf_res", res, 32'h0000_ABCD);
        end
        @(negedge clk); ws_allow_in = 1'b1; #1;
        chk("lhu_rel_res", res, 32'h0000_ABCD);
        chk("lhu_rel_allow", ms_allow_in, 1);
        @(negedge clk); #1;
        chk("lhu_gone", ms_to_ws_valid, 0);

        // Flush a waiting load, then a new load ignores the orphaned response
        es_to_ms_valid = 1'b1; es_to_ms_bus = mk(3'd0, 1'b1, 1'b1, 5'd4, 32'h400, 32'h3000);
        @(negedge clk); es_to_ms_valid = 1'b0; flush = 1'b1; #1;
        chk("flush_valid", ms_to_ws_valid, 0);
        @(negedge clk); flush = 1'b0;
        es_to_ms_valid = 1'b1; es_to_ms_bus = mk(3'd0, 1'b1, 1'b1, 5'd6, 32'h404, 32'h3004); #1;
        chk("flush_allow", ms_allow_in, 1);
        @(negedge clk); es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_0000; #1;
        chk("discard_valid", ms_to_ws_valid, 0);
        chk("discard_block", fwd_block, 1);
        @(negedge clk); data_sram_rdata = 32'h0000_0011; #1;
        chk("after_flush_valid", ms_to_ws_valid, 1);
        chk("after_flush_res", res, 32'h0000_0011);
        @(negedge clk); data_sram_data_ok = 1'b0; #1;
        chk("after_flush_gone", ms_to_ws_valid, 0);

        // Back-to-back ALU entries
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            es_to_ms_valid = (i < 4);
            es_to_ms_bus   = mk(3'd0, 1'b0, 1'b1, 5'(i + 10), 32'h500 + 32'(4 * i), 32'hA0 + 32'(i));
            #1;
            chk("b2b_valid", ms_to_ws_valid, (i > 0));
            chk("b2b_allow", ms_allow_in, 1);
            if (i > 0) begin
                chk("b2b_bus", ms_to_ws_bus,
                    {1'b1, 5'(i + 9), 32'h500 + 32'(4 * (i - 1)), 32'hA0 + 32'(i - 1)});
            end
        end
        es_to_ms_valid = 1'b0;

        // Reset while an orphan is pending and a load waits
        @(negedge clk);
        es_to_ms_valid = 1'b1; es_to_ms_bus = mk(3'd0, 1'b1, 1'b1, 5'd8, 32'h600, 32'h4000);
        @(negedge clk); es_to_ms_valid = 1'b0; flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        es_to_ms_valid = 1'b1; es_to_ms_bus = mk(3'd0, 1'b1, 1'b1, 5'd8, 32'h604, 32'h4004);
        @(negedge clk); es_to_ms_valid = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        chk("midrst_valid", ms_to_ws_valid, 0);
        chk("midrst_fwd_we", fwd_we, 0);
        chk("midrst_block", fwd_block, 0);
        chk("midrst_allow", ms_allow_in, 1);
        es_to_ms_valid = 1'b1; es_to_ms_bus = mk(3'd0, 1'b1, 1'b1, 5'd2, 32'h700, 32'h5000);
        @(negedge clk); es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_0077; #1;
        chk("midrst_cnt0_valid", ms_to_ws_valid, 1);
        chk("midrst_cnt0_res", res, 32'h0000_0077);
        @(negedge clk); data_sram_data_ok = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;

        // Randomized traffic against the model
        m_valid = 0; m_has = 0; m_mreq = 0; m_we = 0;
        m_op = '0; m_dest = '0; m_pc = '0; m_alu = '0; m_data = '0;
        resp_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            flush          = ($urandom_range(0, 9) == 0);
            ws_allow_in    = ($urandom_range(0, 3) != 0);
            es_to_ms_valid = $urandom_range(0, 1) != 0;
            op   = 3'($urandom_range(0, 7));
            mreq = (resp_q.size() < 2) && ($urandom_range(0, 1) != 0);
            we   = $urandom_range(0, 1) != 0;
            dst  = 5'($urandom_range(0, 31));
            pcv  = $urandom;
            alu  = $urandom;
            es_to_ms_bus      = mk(op, mreq, we, dst, pcv, alu);
            data_sram_data_ok = (resp_q.size() > 0) && ($urandom_range(0, 1) != 0);
            data_sram_rdata   = $urandom;
            #1;

            got    = m_valid && m_mreq && !m_has && data_sram_data_ok && resp_q[0];
            ready  = !m_mreq || m_has || got;
            allow  = !m_valid || (ready && ws_allow_in);
            ovalid = m_valid && ready && !flush;
            exp_res = m_mreq ? ref_ext(m_op, m_alu[1:0], m_has ? m_data : data_sram_rdata)
                             : m_alu;
            chk("rnd_valid", ms_to_ws_valid, ovalid);
            chk("rnd_allow", ms_allow_in, allow);
            chk("rnd_fwd_we", fwd_we, m_valid && m_we);
            chk("rnd_fwd_block", fwd_block, m_valid && m_mreq && !ready);
            if (ovalid) begin
                chk("rnd_bus", ms_to_ws_bus, {m_we, m_dest, m_pc, exp_res});
            end

            if (data_sram_data_ok) void'(resp_q.pop_front());
            if (flush) begin
                foreach (resp_q[i]) resp_q[i] = 1'b0;
            end
            if (flush || (ovalid && ws_allow_in)) begin
                m_has = 0;
            end else if (got && !ws_allow_in) begin
                m_has  = 1;
                m_data = data_sram_rdata;
            end
            if (allow && es_to_ms_valid && mreq) resp_q.push_back(!flush);
            if (allow || flush) m_valid = es_to_ms_valid && !flush;
            if (allow && es_to_ms_valid && !flush) begin
                m_op = op; m_mreq = mreq; m_we = we; m_dest = dst; m_pc = pcv; m_alu = alu;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
